// File: rtl/audio_pkg.sv
// Shared types, limits and mix weights for the audio mixer and its DC blocker.
// The mix helper encodes source priority: Covox, then PSG, then beeper alone.
package audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic        [9:0]  mix_t;
  typedef logic signed [16:0] xval_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  localparam int COVOX_SHIFT    = 1;
  localparam int PSG_AC_SHIFT   = 1;
  localparam int SPK_MIX_SHIFT  = 5;
  localparam int SPK_SOLO_SHIFT = 7;
  localparam int MIX_TO_X_SHIFT = 6;

  // Worst case is PSG with all inputs at full scale: 510 + 255 + 224 = 989.
  function automatic mix_t mix_sum(
    input logic       cov_en,
    input logic       psg_en,
    input logic [7:0] cov,
    input logic [7:0] pa,
    input logic [7:0] pb,
    input logic [2:0] spk
  );
    mix_t m;
    if (cov_en)
      m = (mix_t'(cov) << COVOX_SHIFT) + (mix_t'(spk) << SPK_MIX_SHIFT);
    else if (psg_en)
      m = (mix_t'(pa) << PSG_AC_SHIFT) + mix_t'(pb) + (mix_t'(spk) << SPK_MIX_SHIFT);
    else
      m = mix_t'(spk) << SPK_SOLO_SHIFT;
    return m;
  endfunction

endpackage

// File: rtl/audio_mixer_dc_blocker.sv
// First-order DC blocker with saturation and priming, one instance per channel.
// Priming makes the first filtered sample after reset or unmute exactly zero.
module dc_blocker
  import audio_pkg::*;
#(
  parameter int DCB_SHIFT = 10
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    valid,
  input  logic    mute,
  input  xval_t   x,
  output sample_t y,
  output logic    sat
);

  logic    primed_q, primed_d;
  xval_t   x_prev_q, x_prev_d;
  sample_t y_prev_q, y_prev_d;
  sample_t y_q, y_d;
  logic    sat_q, sat_d;

  logic signed [18:0] x_e, xp_e, yp_e, yd_e, acc;

  always_comb begin
    x_e  = x;
    xp_e = x_prev_q;
    yp_e = y_prev_q;
    yd_e = y_prev_q >>> DCB_SHIFT;
    acc  = x_e - xp_e + yp_e - yd_e;

    primed_d = primed_q;
    x_prev_d = x_prev_q;
    y_prev_d = y_prev_q;
    y_d      = y_q;
    sat_d    = sat_q;

    // Mute holds the filter cleared every cycle so unmute always re-primes.
    if (mute) begin
      primed_d = 1'b0;
      x_prev_d = '0;
      y_prev_d = '0;
      if (valid) begin
        y_d   = '0;
        sat_d = 1'b0;
      end
    end else if (valid) begin
      if (!primed_q) begin
        primed_d = 1'b1;
        x_prev_d = x;
        y_prev_d = '0;
        y_d      = '0;
        sat_d    = 1'b0;
      end else begin
        x_prev_d = x;
        if (acc > 19'sd32767) begin
          y_d   = SAMPLE_MAX;
          sat_d = 1'b1;
        end else if (acc < -19'sd32768) begin
          y_d   = SAMPLE_MIN;
          sat_d = 1'b1;
        end else begin
          y_d   = acc[15:0];
          sat_d = 1'b0;
        end
        y_prev_d = y_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed_q <= 1'b0;
      x_prev_q <= '0;
      y_prev_q <= '0;
      y_q      <= '0;
      sat_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
      y_q      <= y_d;
      sat_q    <= sat_d;
    end
  end

  assign y   = y_q;
  assign sat = sat_q;

endmodule

// File: rtl/audio_mixer.sv
// Sample-rate stereo mixer: tick-sampled sources, unsigned mix, offset to signed,
// DC-blocked and saturated, then registered with a one-cycle strobe.
module audio_mixer
  import audio_pkg::*;
#(
  parameter int CLK_RATE    = 96_000_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int DCB_SHIFT   = 10
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [2:0] spk_out,
  input  logic [5:0] psg_active,
  input  logic [7:0] channel_a,
  input  logic [7:0] channel_b,
  input  logic [7:0] channel_c,
  input  logic       covox_enable,
  input  logic [7:0] covox_l,
  input  logic [7:0] covox_r,
  input  logic       mute,
  output sample_t    sample_l,
  output sample_t    sample_r,
  output logic       sample_stb,
  output logic       clip
);

  localparam int DIV = CLK_RATE / SAMPLE_RATE;
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  logic       s0_vld_q, s0_vld_d;
  logic [2:0] spk_q, spk_d;
  logic       psg_en_q, psg_en_d;
  logic [7:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic       cov_en_q, cov_en_d;
  logic [7:0] cov_l_q, cov_l_d, cov_r_q, cov_r_d;

  logic s1_vld_q, s1_vld_d;
  mix_t mix_l_q, mix_l_d, mix_r_q, mix_r_d;

  logic  s2_vld_q, s2_vld_d;
  xval_t x_l_q, x_l_d, x_r_q, x_r_d;

  logic    s3_vld_q, s3_vld_d;
  sample_t y_l, y_r;
  logic    sat_l, sat_r;

  sample_t out_l_q, out_l_d, out_r_q, out_r_d;
  logic    stb_q, stb_d, clip_q, clip_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);

    s0_vld_d = tick;
    spk_d    = spk_q;
    psg_en_d = psg_en_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cov_en_d = cov_en_q;
    cov_l_d  = cov_l_q;
    cov_r_d  = cov_r_q;
    if (tick) begin
      spk_d    = spk_out;
      psg_en_d = |psg_active;
      a_d      = channel_a;
      b_d      = channel_b;
      c_d      = channel_c;
      cov_en_d = covox_enable;
      cov_l_d  = covox_l;
      cov_r_d  = covox_r;
    end

    s1_vld_d = s0_vld_q;
    mix_l_d  = mix_l_q;
    mix_r_d  = mix_r_q;
    if (s0_vld_q) begin
      mix_l_d = mix_sum(cov_en_q, psg_en_q, cov_l_q, a_q, b_q, spk_q);
      mix_r_d = mix_sum(cov_en_q, psg_en_q, cov_r_q, c_q, b_q, spk_q);
    end

    // Full-scale unsigned mix maps onto the signed 16-bit range around zero.
    s2_vld_d = s1_vld_q;
    x_l_d    = x_l_q;
    x_r_d    = x_r_q;
    if (s1_vld_q) begin
      x_l_d = $signed({1'b0, mix_l_q, 6'b0}) - 17'sd32768;
      x_r_d = $signed({1'b0, mix_r_q, 6'b0}) - 17'sd32768;
    end

    s3_vld_d = s2_vld_q;

    stb_d   = s3_vld_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    clip_d  = 1'b0;
    if (s3_vld_q) begin
      out_l_d = y_l;
      out_r_d = y_r;
      clip_d  = sat_l | sat_r;
    end
  end

  dc_blocker #(.DCB_SHIFT(DCB_SHIFT)) u_dcb_l (
    .clk   (clk_sys),
    .reset (reset),
    .valid (s2_vld_q),
    .mute  (mute),
    .x     (x_l_q),
    .y     (y_l),
    .sat   (sat_l)
  );

  dc_blocker #(.DCB_SHIFT(DCB_SHIFT)) u_dcb_r (
    .clk   (clk_sys),
    .reset (reset),
    .valid (s2_vld_q),
    .mute  (mute),
    .x     (x_r_q),
    .y     (y_r),
    .sat   (sat_r)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      s0_vld_q <= 1'b0;
      spk_q    <= '0;
      psg_en_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      cov_en_q <= 1'b0;
      cov_l_q  <= '0;
      cov_r_q  <= '0;
      s1_vld_q <= 1'b0;
      mix_l_q  <= '0;
      mix_r_q  <= '0;
      s2_vld_q <= 1'b0;
      x_l_q    <= '0;
      x_r_q    <= '0;
      s3_vld_q <= 1'b0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      stb_q    <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      s0_vld_q <= s0_vld_d;
      spk_q    <= spk_d;
      psg_en_q <= psg_en_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cov_en_q <= cov_en_d;
      cov_l_q  <= cov_l_d;
      cov_r_q  <= cov_r_d;
      s1_vld_q <= s1_vld_d;
      mix_l_q  <= mix_l_d;
      mix_r_q  <= mix_r_d;
      s2_vld_q <= s2_vld_d;
      x_l_q    <= x_l_d;
      x_r_q    <= x_r_d;
      s3_vld_q <= s3_vld_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      stb_q    <= stb_d;
      clip_q   <= clip_d;
    end
  end

  assign sample_l   = out_l_q;
  assign sample_r   = out_r_q;
  assign sample_stb = stb_q;
  assign clip       = clip_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed bench for audio_mixer at default parameters; expected samples are
// hand-derived from the mix, offset and DC-blocker equations.
module tb_audio_mixer;

  logic               clk_sys = 1'b0;
  logic               reset;
  logic [2:0]         spk_out;
  logic [5:0]         psg_active;
  logic [7:0]         channel_a, channel_b, channel_c;
  logic               covox_enable;
  logic [7:0]         covox_l, covox_r;
  logic               mute;
  logic signed [15:0] sample_l, sample_r;
  logic               sample_stb, clip;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk_sys = ~clk_sys;

  audio_mixer dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .spk_out      (spk_out),
    .psg_active   (psg_active),
    .channel_a    (channel_a),
    .channel_b    (channel_b),
    .channel_c    (channel_c),
    .covox_enable (covox_enable),
    .covox_l      (covox_l),
    .covox_r      (covox_r),
    .mute         (mute),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_stb   (sample_stb),
    .clip         (clip)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of rising edges until sample_stb is seen high.
  task automatic wait_stb(output int cycles);
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_sys);
      #1;
      cycles++;
      if (sample_stb) return;
    end
    checks++;
    errors++;
    $error("FAIL strobe_timeout observed none expected strobe within 3000 cycles");
  endtask

  task automatic chk_lr(input string tag, input int l, input int r, input int c);
    chk({tag, "_l"}, int'(sample_l), l);
    chk({tag, "_r"}, int'(sample_r), r);
    chk({tag, "_clip"}, int'(clip), c);
  endtask

  initial begin
    reset        = 1'b1;
    spk_out      = '0;
    psg_active   = '0;
    channel_a    = '0;
    channel_b    = '0;
    channel_c    = '0;
    covox_enable = 1'b0;
    covox_l      = '0;
    covox_r      = '0;
    mute         = 1'b0;

    repeat (3) @(posedge clk_sys);
    #1;
    chk_lr("reset", 0, 0, 0);
    chk("reset_stb", int'(sample_stb), 0);

    @(posedge clk_sys);
    #1 reset = 1'b0;
    wait_stb(n);
    chk("first_stb_delay", n, 2004);
    chk_lr("prime_silence", 0, 0, 0);
    @(posedge clk_sys);
    #1;
    chk("stb_width", int'(sample_stb), 0);

    wait_stb(n);
    chk("stb_period", n + 1, 2000);
    chk_lr("silence", 0, 0, 0);

    // Beeper step: mix 896, x 24576, raw y 57344 saturates.
    spk_out = 3'd7;
    wait_stb(n);
    chk("stb_period2", n, 2000);
    chk_lr("spk_step", 32767, 32767, 1);

    repeat (1000) @(posedge clk_sys);
    #1;
    chk("hold_l", int'(sample_l), 32767);
    chk("hold_stb", int'(sample_stb), 0);

    wait_stb(n);
    chk_lr("spk_decay", 32736, 32736, 0);

    mute = 1'b1;
    wait_stb(n);
    chk_lr("mute", 0, 0, 0);

    // PSG: L mix = 2a+b, R mix = 2c+b; unmute primes to zero.
    spk_out    = 3'd0;
    psg_active = 6'd1;
    channel_a  = 8'd0;
    channel_b  = 8'd50;
    channel_c  = 8'd0;
    mute       = 1'b0;
    wait_stb(n);
    chk_lr("psg_prime", 0, 0, 0);

    channel_a = 8'd200;
    wait_stb(n);
    chk_lr("psg_step", 25600, 0, 0);
    wait_stb(n);
    chk_lr("psg_decay", 25575, 0, 0);

    mute = 1'b1;
    wait_stb(n);
    chk_lr("mute2", 0, 0, 0);

    covox_enable = 1'b1;
    covox_l      = 8'd0;
    covox_r      = 8'd0;
    mute         = 1'b0;
    wait_stb(n);
    chk_lr("covox_prime", 0, 0, 0);

    channel_a = 8'd10;
    channel_b = 8'd10;
    channel_c = 8'd10;
    wait_stb(n);
    chk_lr("covox_psg_ignored", 0, 0, 0);

    covox_l = 8'd100;
    wait_stb(n);
    chk_lr("covox_l_step", 12800, 0, 0);

    covox_r = 8'd50;
    wait_stb(n);
    chk_lr("covox_r_step", 12788, 6400, 0);

    // Reset while the next sample sits in S2.
    repeat (1998) @(posedge clk_sys);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_sys);
      #1;
      chk("reset_mid_stb", int'(sample_stb), 0);
    end
    chk_lr("reset_mid", 0, 0, 0);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    wait_stb(n);
    chk("stb_after_reset", n, 2004);
    chk_lr("prime_after_reset", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
